ft_bus_arbiter: RTL
===================

# ft_bus_arbiter

Half-duplex scheduler for the FT600 245-synchronous FIFO bus, in the `ft_clk` domain between the FT600 pins and the design's streaming logic. It shares the single bidirectional data bus between a TX stream (FPGA to host) and an RX stream (host to FPGA). It sequences OE/RD/WR strobes and bus turnaround, and bounds each burst so neither direction starves the other. Pin tristating lives at top level; this block exposes separate in/out/enable buses.

## Interface
- `DATA_W`, 16, FT data bus width (byte enables = `DATA_W/8`)
- `MAX_BURST`, 64, max words per direction grant before forced re-arbitration (≥1)
- `ft_clk` in 1 — FT600 clock, sole clock
- `rst` in 1 — reset, asynchronous, active-high
- `ft_rxf_n` in 1 — FT600 RX data available (low = host has data)
- `ft_txe_n` in 1 — FT600 TX space available (low = can write)
- `ft_data_i` in DATA_W — bus input sample
- `ft_data_o` out DATA_W — bus output value
- `ft_data_oe` out 1 — FPGA drives data/BE pins when 1
- `ft_be_o` out DATA_W/8 — write byte enables, constant all-ones
- `ft_oe_n`, `ft_rd_n`, `ft_wr_n` out 1 each — FT600 strobes, active-low
- `tx_data` in DATA_W, `tx_valid` in 1, `tx_ready` out 1 — TX stream
- `rx_data` out DATA_W, `rx_valid` out 1, `rx_ready` in 1 — RX stream
- `busy` out 1 — state ≠ IDLE

## Operation
- States: IDLE, RD_OE, RD, TURN, WR.
- `rx_pend = !ft_rxf_n && rx_ready`; `tx_pend = !ft_txe_n && tx_valid`.
- IDLE: only `rx_pend` → RD_OE; only `tx_pend` → WR; both → direction opposite to `last_dir`; neither → stay.
- RD_OE: `ft_oe_n`=0, `ft_rd_n`=1, one cycle → RD. `last_dir`←RX.
- RD: `ft_oe_n`=0. `ft_rd_n = !rx_pend`. Word transferred on each edge where `rx_pend`. `rx_valid = rx_pend`, `rx_data = ft_data_i` (combinational). Exit → TURN when `!rx_pend`, or when the transfer completing on this edge is the `MAX_BURST`-th.
- TURN: `ft_oe_n`=1, all strobes high, one cycle → IDLE.
- WR: `ft_data_oe`=1. `ft_wr_n = !tx_pend`, `tx_ready = tx_pend`, `ft_data_o = tx_data`. `last_dir`←TX on entry. Exit → IDLE when `!tx_pend` or on the `MAX_BURST`-th transfer.
- Burst counter clears on entry to RD_OE/WR. It increments per transfer, width `$clog2(MAX_BURST+1)`.
- `ft_data_oe` is 1 only in WR. `ft_oe_n` is 0 only in RD_OE/RD. These never overlap.
- Outside RD/WR: `rx_valid`=0, `tx_ready`=0.

## Timing
- Reset values: state IDLE, `ft_oe_n`=`ft_rd_n`=`ft_wr_n`=1, `ft_data_oe`=0, `ft_data_o`=0, `ft_be_o`=all-ones, `rx_valid`=0, `tx_ready`=0, `busy`=0, `last_dir`=TX (RX wins first tie), counter 0.
- Read latency: IDLE→first RX word ≥2 edges (RD_OE + RD). Read-to-write switch costs 1 TURN cycle. Write-to-read costs 0 extra (IDLE then RD_OE).
- `ft_rxf_n`/`ft_txe_n` deassert mid-burst: the strobe deasserts the same cycle with no transfer, then the state exits.
- `MAX_BURST`=1: one word per grant, strict alternation when both pending.
- Reset asserted mid-burst: strobes high and `ft_data_oe`=0 immediately (asynchronous), without waiting for the clock.

## Configuration
- `FT_ARB_STATS_EN` defined: adds outputs `rx_count` and `tx_count`, each 32 bits, cleared by reset. Each increments per transferred word and wraps at 2^32. Also adds `grant_count`, 16 bits, which increments on each entry to RD_OE or WR and wraps.
- Undefined: these ports and their counters are absent.

## Test plan
- Reset then idle (`ft_rxf_n`=`ft_txe_n`=1): all strobes 1, `ft_data_oe`=0, `busy`=0 for 20 cycles.
- TX only, `tx_valid`=1, `ft_txe_n`=0, data 0x0000..0x0009, `MAX_BURST`=64: WR on the first edge; 10 words are written in order with `ft_wr_n`=0; the block returns to IDLE when `tx_valid` drops.
- RX only, host supplies 5 words 0xA000..0xA004: `ft_oe_n` is low one cycle before `ft_rd_n`; `rx_valid`/`rx_data` carry 5 words; TURN occurs, then IDLE.
- Both pending continuously with `MAX_BURST`=4: grants alternate RX(4), TX(4), RX(4), with exactly one TURN cycle after each RX burst and `ft_data_oe`/`ft_oe_n` never active together.
- `rx_ready` dropped after word 2 of an RX burst: `ft_rd_n` rises the same cycle; exactly 2 words are delivered; TURN follows; pending TX is then served.
- `rst` pulsed asynchronously mid-WR: `ft_wr_n`=1 and `ft_data_oe`=0 before the next `ft_clk` edge. With `FT_ARB_STATS_EN`, the counters read 0 afterwards.

Source files
------------

// File: rtl/ft_bus_arbiter.sv
// ft_bus_arbiter: half-duplex FT600 245-sync bus scheduler (RX/TX burst arbitration with turnaround).
// Define FT_ARB_STATS_EN to add rx_count/tx_count/grant_count statistics outputs.
module ft_bus_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 64
) (
    input  logic                ft_clk,
    input  logic                rst,
    input  logic                ft_rxf_n,
    input  logic                ft_txe_n,
    input  logic [DATA_W-1:0]   ft_data_i,
    output logic [DATA_W-1:0]   ft_data_o,
    output logic                ft_data_oe,
    output logic [DATA_W/8-1:0] ft_be_o,
    output logic                ft_oe_n,
    output logic                ft_rd_n,
    output logic                ft_wr_n,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                busy
`ifdef FT_ARB_STATS_EN
    ,
    output logic [31:0]         rx_count,
    output logic [31:0]         tx_count,
    output logic [15:0]         grant_count
`endif
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {IDLE, RD_OE, RD, TURN, WR} state_t;

    state_t        state_q, state_d;
    logic          last_rx_q, last_rx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rx_pend, tx_pend, rx_xfer, tx_xfer, last_word;

    assign rx_pend   = !ft_rxf_n && rx_ready;
    assign tx_pend   = !ft_txe_n && tx_valid;
    assign rx_xfer   = state_q == RD && rx_pend;
    assign tx_xfer   = state_q == WR && tx_pend;
    assign last_word = cnt_q == CW'(MAX_BURST - 1);

    always_comb begin
        state_d   = state_q;
        last_rx_d = last_rx_q;
        cnt_d     = (rx_xfer || tx_xfer) ? cnt_q + CW'(1) : cnt_q;
        case (state_q)
            IDLE: begin
                // On a tie the direction not served last wins
                if (rx_pend && (!tx_pend || !last_rx_q)) begin
                    state_d   = RD_OE;
                    last_rx_d = 1'b1;
                    cnt_d     = '0;
                end else if (tx_pend) begin
                    state_d   = WR;
                    last_rx_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            RD_OE:   state_d = RD;
            RD:      state_d = (!rx_pend || last_word) ? TURN : RD;
            TURN:    state_d = IDLE;
            WR:      state_d = (!tx_pend || last_word) ? IDLE : WR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ft_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_rx_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_rx_q <= last_rx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Strobes decode straight from state so an async reset releases the bus at once
    assign ft_oe_n    = !(state_q == RD_OE || state_q == RD);
    assign ft_rd_n    = !rx_xfer;
    assign ft_wr_n    = !tx_xfer;
    assign ft_data_oe = state_q == WR;
    assign ft_data_o  = ft_data_oe ? tx_data : '0;
    assign ft_be_o    = '1;
    assign rx_valid   = rx_xfer;
    assign rx_data    = ft_data_i;
    assign tx_ready   = tx_xfer;
    assign busy       = state_q != IDLE;

`ifdef FT_ARB_STATS_EN
    logic [31:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    logic [15:0] grant_count_q, grant_count_d;

    always_comb begin
        rx_count_d    = rx_count_q + 32'(rx_xfer);
        tx_count_d    = tx_count_q + 32'(tx_xfer);
        grant_count_d = grant_count_q + 16'(state_q == IDLE && state_d != IDLE);
    end

    always_ff @(posedge ft_clk or posedge rst) begin
        if (rst) begin
            rx_count_q    <= '0;
            tx_count_q    <= '0;
            grant_count_q <= '0;
        end else begin
            rx_count_q    <= rx_count_d;
            tx_count_q    <= tx_count_d;
            grant_count_q <= grant_count_d;
        end
    end

    assign rx_count    = rx_count_q;
    assign tx_count    = tx_count_q;
    assign grant_count = grant_count_q;
`endif
endmodule
